// File: rtl/sram_model_pkg.sv
// Shared widths, types and byte-merge helper for the 256 x 32 SRAM behavioural model.
// Every file takes its widths from this package.
package sram_model_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int STRB_W = DATA_W / 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] word_t;
    typedef logic [STRB_W-1:0] strb_t;

    // Access decoded from one cycle's control inputs.
    typedef enum logic [1:0] {
        ACC_IDLE,
        ACC_READ,
        ACC_WRITE,
        ACC_RESET
    } acc_e;

    // Returns old_w with every strobed byte replaced by the matching byte of new_w.
    function automatic word_t apply_strobe(input word_t old_w, input word_t new_w,
                                           input strb_t strb);
        word_t merged;
        merged = old_w;
        for (int k = 0; k < STRB_W; k++) begin
            if (strb[k]) begin
                merged[8*k +: 8] = new_w[8*k +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_model_if.sv
// Macro-style SRAM port bundle: address, active-low enables, byte strobes, data in and registered data out.
// The master drives an access; the slave (the SRAM) returns io_q.
interface sram_model_if;
    import sram_model_pkg::*;

    addr_t io_adr;
    logic  io_cen;
    logic  io_wen;
    strb_t io_wstrb;
    word_t io_d;
    word_t io_q;

    modport master (
        output io_adr, io_cen, io_wen, io_wstrb, io_d,
        input  io_q
    );

    modport slave (
        input  io_adr, io_cen, io_wen, io_wstrb, io_d,
        output io_q
    );

endinterface

// File: rtl/sram_model_core.sv
// Single-port synchronous SRAM model: 256 x 32-bit words with byte write strobes and 1-cycle registered read.
// The array `mem` is loaded and inspected by benches through hierarchical references.
module sram_model_core
    import sram_model_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    sram_model_if.slave bus
);

    reg [DATA_W-1:0] mem [0:DEPTH-1];

    acc_e  w_acc;
    word_t w_rd_word;
    word_t w_wr_word;
    word_t r_q;

    // An X on io_cen or io_wen fails both equality tests, so the access decodes as idle.
    always_comb begin
        w_acc = ACC_IDLE;
        if (reset) begin
            w_acc = ACC_RESET;
        end else if (bus.io_cen == 1'b0) begin
            if (bus.io_wen == 1'b0) begin
                w_acc = ACC_WRITE;
            end else if (bus.io_wen == 1'b1) begin
                w_acc = ACC_READ;
            end
        end
    end

    assign w_rd_word = mem[bus.io_adr];
    assign w_wr_word = apply_strobe(w_rd_word, bus.io_d, bus.io_wstrb);

    // NOTE: the array has no reset branch; contents persist across reset, and preloaded data must survive.
    always_ff @(posedge clock) begin : storage
        if (w_acc == ACC_WRITE) begin
            mem[bus.io_adr] <= w_wr_word;
        end
    end

    // NOTE: non-blocking assignment, so a same-edge reader sees the pre-edge value.
    always_ff @(posedge clock) begin : read_port
        if (w_acc == ACC_RESET) begin
            r_q <= '0;
        end else if (w_acc == ACC_READ) begin
            r_q <= w_rd_word;
        end
    end

    assign bus.io_q = r_q;

endmodule

// File: tb/tb_sram_model_core.sv
// Directed and random bench for sram_model_core: a scoreboard checks io_q, and a reference checker
// runs beside the design and checks it every cycle.
module sram_ref_checker
    import sram_model_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  addr_t io_adr,
    input  logic  io_cen,
    input  logic  io_wen,
    input  strb_t io_wstrb,
    input  word_t io_d,
    input  word_t io_q,
    output int    o_checks,
    output int    o_errors
);

    word_t ref_mem [0:DEPTH-1];
    word_t ref_q = '0;
    bit    armed = 1'b0;
    int    n_checks = 0;
    int    n_errors = 0;

    assign o_checks = n_checks;
    assign o_errors = n_errors;

    // The bench mirrors every backdoor load into this array.
    task automatic sync_word(input addr_t a, input word_t v);
        ref_mem[a] = v;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            ref_q <= '0;
            armed <= 1'b1;
        end else if (io_cen === 1'b0 && io_wen === 1'b0) begin
            for (int k = 0; k < STRB_W; k++) begin
                if (io_wstrb[k] === 1'b1) begin
                    ref_mem[io_adr][8*k +: 8] <= io_d[8*k +: 8];
                end
            end
        end else if (io_cen === 1'b0 && io_wen === 1'b1) begin
            ref_q <= ref_mem[io_adr];
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            n_checks++;
            if (io_q !== ref_q) begin
                n_errors++;
                $display("FAIL ref_q: io_q=%h model=%h at %0t", io_q, ref_q, $time);
                $error("reference checker: io_q differs from model");
            end
        end
    end

endmodule

module tb_sram_model_core;
    import sram_model_pkg::*;

    typedef struct {
        int    cyc;
        string name;
        word_t exp;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   chk_checks;
    int   chk_errors;
    int   checks = 0;
    int   errors = 0;
    int   cyc_cnt = 0;
    exp_t sb_q[$];

    sram_model_if bus ();

    sram_model_core u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    sram_ref_checker u_chk (
        .clk      (clock),
        .rst      (reset),
        .io_adr   (bus.io_adr),
        .io_cen   (bus.io_cen),
        .io_wen   (bus.io_wen),
        .io_wstrb (bus.io_wstrb),
        .io_d     (bus.io_d),
        .io_q     (bus.io_q),
        .o_checks (chk_checks),
        .o_errors (chk_errors)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected io_q after the upcoming posedge.
    task automatic expect_q(input string name, input word_t exp);
        sb_q.push_back('{cyc_cnt + 1, name, exp});
    endtask

    task automatic step(input logic rst_v, input logic cen_v, input logic wen_v,
                        input addr_t a, input strb_t s, input word_t dv);
        @(negedge clock);
        reset        = rst_v;
        bus.io_cen   = cen_v;
        bus.io_wen   = wen_v;
        bus.io_adr   = a;
        bus.io_wstrb = s;
        bus.io_d     = dv;
    endtask

    task automatic bd_write(input addr_t a, input word_t v);
        u_dut.mem[a] = v;
        u_chk.sync_word(a, v);
    endtask

    // Scoreboard monitor: io_q is valid every cycle, so pop whatever is due this cycle.
    always @(negedge clock) begin : monitor
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc_cnt) begin
            e = sb_q.pop_front();
            check(e.name, bus.io_q, e.exp);
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        reset        = 1'b1;
        bus.io_cen   = 1'b1;
        bus.io_wen   = 1'b1;
        bus.io_adr   = '0;
        bus.io_wstrb = '0;
        bus.io_d     = '0;
        for (int i = 0; i < DEPTH; i++) bd_write(addr_t'(i), word_t'(i));

        step(1, 0, 0, 8'h20, 4'hF, 32'h12345678); expect_q("reset_q",          32'h0000_0000);
        step(0, 0, 1, 8'h05, 4'h0, 32'h0);        expect_q("read_5",           32'h0000_0005);
        step(0, 0, 0, 8'h03, 4'hF, 32'hDEADBEEF); expect_q("write_holds_q",    32'h0000_0005);
        step(0, 0, 1, 8'h03, 4'h0, 32'h0);        expect_q("raw_3",            32'hDEADBEEF);
        bd_write(8'h07, 32'h0000_0007);
        step(0, 0, 0, 8'h07, 4'b0101, 32'hAABBCCDD); expect_q("strobe_hold",   32'hDEADBEEF);
        step(0, 0, 1, 8'h07, 4'h0, 32'h0);        expect_q("strobe_0101_rd",   32'h00BB00DD);
        step(0, 1, 0, 8'h09, 4'hF, 32'hFFFFFFFF); expect_q("disabled_hold",    32'h00BB00DD);
        step(0, 0, 1, 8'h09, 4'h0, 32'h0);        expect_q("disabled_rd_9",    32'h0000_0009);
        step(0, 0, 0, 8'h04, 4'h0, 32'hFFFFFFFF); expect_q("nostrb_hold",      32'h0000_0009);
        step(0, 0, 1, 8'h04, 4'h0, 32'h0);        expect_q("nostrb_rd_4",      32'h0000_0004);
        step(0, 0, 0, 8'h04, 4'b1000, 32'h11223344); expect_q("msb_hold",      32'h0000_0004);
        step(0, 0, 1, 8'h04, 4'h0, 32'h0);        expect_q("msb_rd_4",         32'h1100_0004);
        step(1, 0, 0, 8'h0A, 4'hF, 32'hCAFEF00D); expect_q("midop_reset_q",    32'h0000_0000);
        step(0, 0, 1, 8'h0A, 4'h0, 32'h0);        expect_q("after_reset_rd_a", 32'h0000_000A);
        step(0, 0, 1, 8'h20, 4'h0, 32'h0);        expect_q("after_reset_rd20", 32'h0000_0020);
        step(0, 0, 0, 8'hFF, 4'hF, 32'hA5A5A5A5); expect_q("top_wr_hold",      32'h0000_0020);
        step(0, 0, 1, 8'h00, 4'h0, 32'h0);        expect_q("rd_addr_0",        32'h0000_0000);
        step(0, 0, 1, 8'hFF, 4'h0, 32'h0);        expect_q("rd_addr_ff",       32'hA5A5A5A5);
        step(0, 1, 1, 8'h00, 4'h0, 32'h0);        expect_q("idle_hold",        32'hA5A5A5A5);
        step(0, 1, 0, 8'hFF, 4'hF, 32'h0);        expect_q("idle_wen0_hold",   32'hA5A5A5A5);
        step(0, 0, 1, 8'hFF, 4'h0, 32'h0);        expect_q("idle_no_write",    32'hA5A5A5A5);
        step(0, 0, 0, 8'h03, 4'b0110, 32'h0);     expect_q("mid_strb_hold",    32'hA5A5A5A5);
        step(0, 0, 1, 8'h03, 4'h0, 32'h0);        expect_q("mid_strb_rd_3",    32'hDE0000EF);
        step(0, 1, 1, 8'h00, 4'h0, 32'h0);

        check("bd_mem7",  u_dut.mem[8'h07], 32'h00BB00DD);
        check("bd_mem9",  u_dut.mem[8'h09], 32'h0000_0009);
        check("bd_mem10", u_dut.mem[8'h0A], 32'h0000_000A);
        check("bd_mem20", u_dut.mem[8'h20], 32'h0000_0020);
        check("bd_mem4",  u_dut.mem[8'h04], 32'h1100_0004);
        check("bd_memff", u_dut.mem[8'hFF], 32'hA5A5A5A5);

        for (int n = 0; n < 2500; n++) begin
            step(1'b0, ($urandom_range(0, 3) == 0), 1'($urandom), addr_t'($urandom),
                 strb_t'($urandom), $urandom);
        end
        step(0, 1, 1, 8'h00, 4'h0, 32'h0);
        step(0, 1, 1, 8'h00, 4'h0, 32'h0);

        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("final_mem[%0d]", i), u_dut.mem[i], u_chk.ref_mem[i]);
        end
        check("sb_drained", word_t'(sb_q.size()), 32'h0);

        errors += chk_errors;
        checks += chk_checks;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
